tblink_rpc_invoke_arb: RTL and testbench
========================================

TBLINK_RPC_INVOKE_ARB -- requirements
Module: tblink_rpc_invoke_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters (2..8).
REQ-002 Parameter MID_W, default 8: method-id width.
REQ-003 Parameter DATA_W, default 64: parameter and result payload width.
REQ-004 Parameter TAG_W, default 2: tag width; 2**TAG_W tags, one per outstanding blocking call.
REQ-005 clock  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 enable  in  1  when 0, no new grants; outstanding calls still complete.
REQ-008 req_valid  in  N_REQ  per-requester invoke request.
REQ-009 req_ready  out  N_REQ  per-requester accept; one-hot or zero.
REQ-010 req_blocking  in  N_REQ  1 = blocking method (needs response), 0 = non-blocking.
REQ-011 req_method  in  N_REQ*MID_W  packed method ids; requester i at [i*MID_W +: MID_W].
REQ-012 req_params  in  N_REQ*DATA_W  packed parameter payloads.
REQ-013 out_valid/out_ready  out/in  1/1  invoke channel toward the DPI bridge.
REQ-014 out_method, out_params, out_blocking, out_tag, out_src  out  MID_W, DATA_W, 1, TAG_W, clog2(N_REQ)  registered invoke fields.
REQ-015 rsp_valid, rsp_tag, rsp_data  in  1, TAG_W, DATA_W  bridge response; always accepted.
REQ-016 cpl_valid  out  N_REQ  one-cycle completion pulse to the originating requester.
REQ-017 cpl_data  out  DATA_W  result for the pulsed requester; shared by all requesters.
REQ-018 busy  out  N_REQ  requester has a blocking call in flight.
REQ-019 outstanding  out  TAG_W+1  count of tags not FREE.
REQ-020 err_unexp_tag  out  1  one-cycle pulse on a response to a non-PENDING tag.

Function
REQ-021 Handshake: transfer on valid&&ready on both channels; out_* SHALL hold stable while out_valid && !out_ready.
REQ-022 Slot free = !out_valid || out_ready; grant only when slot free && enable.
REQ-023 Eligible(i) = req_valid[i] && !busy[i] && (!req_blocking[i] || a FREE tag exists).
REQ-024 Round-robin among eligible, starting from the requester after last grant; after reset search starts at requester 0.
REQ-025 req_ready[i] combinational, asserted only for the granted requester in the grant cycle.
REQ-026 Latency: out_valid asserts the cycle after a request handshake; sustained throughput 1 invoke/cycle.
REQ-027 Blocking grant: allocate lowest-numbered FREE tag, record src, set busy[src], tag state FREE->ISSUED; out_tag = tag.
REQ-028 Non-blocking grant: no tag allocated, busy unchanged, out_tag = 0; complete at out handshake, no cpl.
REQ-029 Tag states: FREE -> ISSUED (grant) -> PENDING (out handshake) -> FREE (response).
REQ-030 Response to a PENDING tag: next cycle cpl_valid[src]=1 and cpl_data=rsp_data; tag FREE and busy[src] cleared in that same next cycle.
REQ-031 Response to a FREE or ISSUED tag: dropped, no state change; err_unexp_tag pulses next cycle.
REQ-032 A tag freed by a response SHALL NOT be reallocated in the cycle the response arrives; busy[src] likewise blocks re-grant that cycle.
REQ-033 All tags non-FREE: blocking requests ineligible; non-blocking requests still granted.
REQ-034 enable deasserted: no grants; a held out_valid remains until accepted.
REQ-035 outstanding = number of ISSUED + PENDING tags, range 0..2**TAG_W.

Reset
REQ-036 On reset: out_valid=0, cpl_valid=0, busy=0, outstanding=0, err_unexp_tag=0, all tags FREE, RR pointer selects requester 0 first.
REQ-037 Reset mid-operation discards in-flight calls; no cpl pulse for them; later responses to their tags flag err_unexp_tag.

Verification
REQ-038 Req0 non-blocking, method 0x05, params 0x1234, out_ready=1 -> out_valid next cycle, out_src=0, out_method=0x05; no cpl; busy=0.
REQ-039 Req1 blocking; rsp_tag=0, rsp_data=0xAA three cycles later -> out_tag=0, busy[1]=1, outstanding=1; then cpl_valid=4'b0010, cpl_data=0xAA, busy=0, outstanding=0.
REQ-040 All 4 requesters non-blocking and continuously valid, out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles.
REQ-041 Five blocking requests from 4 requesters re-issuing, no responses -> 4 tags allocated (0..3), outstanding=4, further blocking requests stalled; a non-blocking request is still granted.
REQ-042 out_ready=0 for 3 cycles with out_valid=1 -> out_* stable, req_ready all 0; rsp_valid with rsp_tag of the held ISSUED tag -> err_unexp_tag pulse, tag unchanged.
REQ-043 reset asserted with 2 tags PENDING -> next cycle outstanding=0, busy=0; later rsp_tag=1 -> err_unexp_tag=1, cpl_valid=0.

Source files
------------

// File: rtl/tblink_rpc_invoke_arb.sv
// Round-robin invoke arbiter for TbLink RPC requesters. Blocking calls get
// a tag that tracks them until the bridge responds; non-blocking calls are
// fire-and-forget once the bridge accepts them.
module tblink_rpc_invoke_arb #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned MID_W  = 8,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned TAG_W  = 2,
    localparam int unsigned SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      enable_i,
    input  logic [N_REQ-1:0]          req_valid_i,
    output logic [N_REQ-1:0]          req_ready_o,
    input  logic [N_REQ-1:0]          req_blocking_i,
    input  logic [N_REQ*MID_W-1:0]    req_method_i,
    input  logic [N_REQ*DATA_W-1:0]   req_params_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [MID_W-1:0]          out_method_o,
    output logic [DATA_W-1:0]         out_params_o,
    output logic                      out_blocking_o,
    output logic [TAG_W-1:0]          out_tag_o,
    output logic [SRC_W-1:0]          out_src_o,
    input  logic                      rsp_valid_i,
    input  logic [TAG_W-1:0]          rsp_tag_i,
    input  logic [DATA_W-1:0]         rsp_data_i,
    output logic [N_REQ-1:0]          cpl_valid_o,
    output logic [DATA_W-1:0]         cpl_data_o,
    output logic [N_REQ-1:0]          busy_o,
    output logic [TAG_W:0]            outstanding_o,
    output logic                      err_unexp_tag_o
);

    localparam int unsigned N_TAG = 2 ** TAG_W;
    localparam int unsigned CNT_W = TAG_W + 1;

    typedef enum logic [1:0] {
        TAG_FREE    = 2'd0,
        TAG_ISSUED  = 2'd1,
        TAG_PENDING = 2'd2
    } tag_st_e;

    tag_st_e             tag_st_q  [N_TAG];
    tag_st_e             tag_st_d  [N_TAG];
    logic [SRC_W-1:0]    tag_src_q [N_TAG];
    logic [SRC_W-1:0]    tag_src_d [N_TAG];
    logic [N_REQ-1:0]    busy_q, busy_d;
    logic [SRC_W-1:0]    rr_q, rr_d;
    logic                out_valid_q, out_valid_d;
    logic [MID_W-1:0]    out_method_q, out_method_d;
    logic [DATA_W-1:0]   out_params_q, out_params_d;
    logic                out_blocking_q, out_blocking_d;
    logic [TAG_W-1:0]    out_tag_q, out_tag_d;
    logic [SRC_W-1:0]    out_src_q, out_src_d;
    logic [N_REQ-1:0]    cpl_valid_q, cpl_valid_d;
    logic [DATA_W-1:0]   cpl_data_q, cpl_data_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    outstanding_q, outstanding_d;

    logic                slot_free;
    logic                tag_avail;
    logic [TAG_W-1:0]    free_tag;
    logic [N_REQ-1:0]    eligible;
    logic                gnt_found;
    logic [SRC_W-1:0]    gnt_idx;

    // Lowest FREE tag and per-requester eligibility, all from registered state
    always_comb begin
        tag_avail = 1'b0;
        free_tag  = '0;
        for (int t = int'(N_TAG) - 1; t >= 0; t--) begin
            if (tag_st_q[t] == TAG_FREE) begin
                tag_avail = 1'b1;
                free_tag  = TAG_W'(t);
            end
        end
        for (int i = 0; i < int'(N_REQ); i++) begin
            eligible[i] = req_valid_i[i] && !busy_q[i] && (!req_blocking_i[i] || tag_avail);
        end
    end

    // Round-robin pick starting at rr_q when the output slot can take a new invoke
    always_comb begin
        slot_free   = !out_valid_q || out_ready_i;
        gnt_found   = 1'b0;
        gnt_idx     = '0;
        req_ready_o = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin : search
            int unsigned idx;
            idx = (32'(rr_q) + 32'(k)) % N_REQ;
            if (!gnt_found && eligible[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = SRC_W'(idx);
            end
        end
        if (!(slot_free && enable_i)) begin
            gnt_found = 1'b0;
        end
        if (gnt_found) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

    // Next state: out handshake, bridge response, then new grant
    always_comb begin
        tag_st_d       = tag_st_q;
        tag_src_d      = tag_src_q;
        busy_d         = busy_q;
        rr_d           = rr_q;
        out_valid_d    = out_valid_q;
        out_method_d   = out_method_q;
        out_params_d   = out_params_q;
        out_blocking_d = out_blocking_q;
        out_tag_d      = out_tag_q;
        out_src_d      = out_src_q;
        cpl_valid_d    = '0;
        cpl_data_d     = cpl_data_q;
        err_d          = 1'b0;
        outstanding_d  = '0;

        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
            if (out_blocking_q) begin
                tag_st_d[out_tag_q] = TAG_PENDING;
            end
        end

        if (rsp_valid_i) begin
            if (tag_st_q[rsp_tag_i] == TAG_PENDING) begin
                tag_st_d[rsp_tag_i]               = TAG_FREE;
                busy_d[tag_src_q[rsp_tag_i]]      = 1'b0;
                cpl_valid_d[tag_src_q[rsp_tag_i]] = 1'b1;
                cpl_data_d                        = rsp_data_i;
            end else begin
                err_d = 1'b1;
            end
        end

        if (gnt_found) begin
            out_valid_d    = 1'b1;
            out_src_d      = gnt_idx;
            out_method_d   = req_method_i[gnt_idx*MID_W +: MID_W];
            out_params_d   = req_params_i[gnt_idx*DATA_W +: DATA_W];
            out_blocking_d = req_blocking_i[gnt_idx];
            rr_d           = (gnt_idx == SRC_W'(N_REQ - 1)) ? '0 : gnt_idx + SRC_W'(1);
            if (req_blocking_i[gnt_idx]) begin
                out_tag_d           = free_tag;
                tag_st_d[free_tag]  = TAG_ISSUED;
                tag_src_d[free_tag] = gnt_idx;
                busy_d[gnt_idx]     = 1'b1;
            end else begin
                out_tag_d = '0;
            end
        end

        for (int t = 0; t < int'(N_TAG); t++) begin
            if (tag_st_d[t] != TAG_FREE) begin
                outstanding_d = outstanding_d + CNT_W'(1);
            end
        end
    end

    // State registers; reset drops all in-flight calls
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int t = 0; t < int'(N_TAG); t++) begin
                tag_st_q[t]  <= TAG_FREE;
                tag_src_q[t] <= '0;
            end
            busy_q         <= '0;
            rr_q           <= '0;
            out_valid_q    <= 1'b0;
            out_method_q   <= '0;
            out_params_q   <= '0;
            out_blocking_q <= 1'b0;
            out_tag_q      <= '0;
            out_src_q      <= '0;
            cpl_valid_q    <= '0;
            cpl_data_q     <= '0;
            err_q          <= 1'b0;
            outstanding_q  <= '0;
        end else begin
            tag_st_q       <= tag_st_d;
            tag_src_q      <= tag_src_d;
            busy_q         <= busy_d;
            rr_q           <= rr_d;
            out_valid_q    <= out_valid_d;
            out_method_q   <= out_method_d;
            out_params_q   <= out_params_d;
            out_blocking_q <= out_blocking_d;
            out_tag_q      <= out_tag_d;
            out_src_q      <= out_src_d;
            cpl_valid_q    <= cpl_valid_d;
            cpl_data_q     <= cpl_data_d;
            err_q          <= err_d;
            outstanding_q  <= outstanding_d;
        end
    end

    assign out_valid_o     = out_valid_q;
    assign out_method_o    = out_method_q;
    assign out_params_o    = out_params_q;
    assign out_blocking_o  = out_blocking_q;
    assign out_tag_o       = out_tag_q;
    assign out_src_o       = out_src_q;
    assign cpl_valid_o     = cpl_valid_q;
    assign cpl_data_o      = cpl_data_q;
    assign busy_o          = busy_q;
    assign outstanding_o   = outstanding_q;
    assign err_unexp_tag_o = err_q;

endmodule

// File: tb/tb_tblink_rpc_invoke_arb.sv
// Bench for tblink_rpc_invoke_arb: scenario tasks push expected invokes into a
// queue; a monitor pops and compares them on each bridge-side handshake.
module tb_tblink_rpc_invoke_arb;

    localparam int unsigned N = 8;

    typedef struct {
        logic [2:0]  src;
        logic [7:0]  method;
        logic [63:0] params;
        logic        blocking;
        logic [1:0]  tag;
    } inv_t;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  req_blocking;
    logic [N*8-1:0]  req_method;
    logic [N*64-1:0] req_params;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_method;
    logic [63:0]   out_params;
    logic          out_blocking;
    logic [1:0]    out_tag;
    logic [2:0]    out_src;
    logic          rsp_valid;
    logic [1:0]    rsp_tag;
    logic [63:0]   rsp_data;
    logic [N-1:0]  cpl_valid;
    logic [63:0]   cpl_data;
    logic [N-1:0]  busy;
    logic [2:0]    outstanding;
    logic          err_unexp_tag;

    int   checks = 0;
    int   errors = 0;
    inv_t exp_q[$];
    inv_t mon_e;

    tblink_rpc_invoke_arb #(.N_REQ(N), .MID_W(8), .DATA_W(64), .TAG_W(2)) dut (
        .clock_i(clk), .reset_i(reset), .enable_i(enable),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_blocking_i(req_blocking),
        .req_method_i(req_method), .req_params_i(req_params),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_method_o(out_method),
        .out_params_o(out_params), .out_blocking_o(out_blocking), .out_tag_o(out_tag),
        .out_src_o(out_src), .rsp_valid_i(rsp_valid), .rsp_tag_i(rsp_tag), .rsp_data_i(rsp_data),
        .cpl_valid_o(cpl_valid), .cpl_data_o(cpl_data), .busy_o(busy),
        .outstanding_o(outstanding), .err_unexp_tag_o(err_unexp_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: just before each rising edge, an accepted invoke must match the queue head
    always @(negedge clk) begin
        #4;
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL invoke_unexpected got src=%0d method=%h exp none", out_src, out_method);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_src !== mon_e.src) begin
                    errors++;
                    $display("FAIL invoke_src got=%0d exp=%0d", out_src, mon_e.src);
                end
                checks++;
                if (out_method !== mon_e.method) begin
                    errors++;
                    $display("FAIL invoke_method got=%h exp=%h", out_method, mon_e.method);
                end
                checks++;
                if (out_params !== mon_e.params) begin
                    errors++;
                    $display("FAIL invoke_params got=%h exp=%h", out_params, mon_e.params);
                end
                checks++;
                if (out_blocking !== mon_e.blocking) begin
                    errors++;
                    $display("FAIL invoke_blocking got=%b exp=%b", out_blocking, mon_e.blocking);
                end
                checks++;
                if (out_tag !== mon_e.tag) begin
                    errors++;
                    $display("FAIL invoke_tag got=%0d exp=%0d", out_tag, mon_e.tag);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic blk, input logic [7:0] m, input logic [63:0] p);
        req_valid[i]         = 1'b1;
        req_blocking[i]      = blk;
        req_method[i*8 +: 8]   = m;
        req_params[i*64 +: 64] = p;
    endtask

    task automatic push_exp(input int s, input logic [7:0] m, input logic [63:0] p,
                            input logic blk, input int t);
        inv_t e;
        e.src = 3'(s); e.method = m; e.params = p; e.blocking = blk; e.tag = 2'(t);
        exp_q.push_back(e);
    endtask

    task automatic apply_reset();
        reset = 1'b1; enable = 1'b1; out_ready = 1'b1;
        req_valid = '0; req_blocking = '0; req_method = '0; req_params = '0;
        rsp_valid = 1'b0; rsp_tag = '0; rsp_data = '0;
        step(); step();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (out_valid !== 1'b0 || cpl_valid !== '0 || err_unexp_tag !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b/%h/%b exp=0/00/0", out_valid, cpl_valid, err_unexp_tag);
        end
        checks++;
        if (busy !== '0 || outstanding !== 3'd0) begin
            errors++;
            $display("FAIL reset_busy_outstanding got=%h/%0d exp=00/0", busy, outstanding);
        end
    endtask

    task automatic test_nonblocking();
        set_req(0, 1'b0, 8'h05, 64'h1234);
        push_exp(0, 8'h05, 64'h1234, 1'b0, 0);
        #1;
        checks++;
        if (req_ready !== 8'h01) begin
            errors++; $display("FAIL nb_ready got=%h exp=01", req_ready);
        end
        step();
        req_valid = '0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL nb_out_valid got=%b exp=1", out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== '0 || cpl_valid !== '0) begin
            errors++; $display("FAIL nb_after got=%b/%h/%h exp=0/00/00", out_valid, busy, cpl_valid);
        end
    endtask

    task automatic test_blocking();
        set_req(1, 1'b1, 8'h11, 64'h55);
        push_exp(1, 8'h11, 64'h55, 1'b1, 0);
        #1;
        checks++;
        if (req_ready !== 8'h02) begin
            errors++; $display("FAIL blk_ready got=%h exp=02", req_ready);
        end
        step();
        req_valid = '0;
        checks++;
        if (out_tag !== 2'd0 || busy !== 8'h02 || outstanding !== 3'd1) begin
            errors++; $display("FAIL blk_issue got=%0d/%h/%0d exp=0/02/1", out_tag, busy, outstanding);
        end
        step();
        step();
        rsp_valid = 1'b1; rsp_tag = 2'd0; rsp_data = 64'hAA;
        step();
        rsp_valid = 1'b0;
        checks++;
        if (cpl_valid !== 8'h02 || cpl_data !== 64'hAA) begin
            errors++; $display("FAIL blk_cpl got=%h/%h exp=02/aa", cpl_valid, cpl_data);
        end
        checks++;
        if (busy !== '0 || outstanding !== 3'd0 || err_unexp_tag !== 1'b0) begin
            errors++; $display("FAIL blk_free got=%h/%0d/%b exp=00/0/0", busy, outstanding, err_unexp_tag);
        end
        step();
        checks++;
        if (cpl_valid !== '0) begin
            errors++; $display("FAIL blk_cpl_pulse got=%h exp=00", cpl_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_rdy;
        apply_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'(8'h20 + i), 64'(64'h100 + i));
        for (int k = 0; k < 5; k++) push_exp(k % 4, 8'(8'h20 + (k % 4)), 64'(64'h100 + (k % 4)), 1'b0, 0);
        for (int k = 0; k < 5; k++) begin
            #1;
            exp_rdy = 8'(1 << (k % 4));
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++; $display("FAIL rr_grant_%0d got=%h exp=%h", k, req_ready, exp_rdy);
            end
            step();
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_tag_exhaust();
        logic [7:0] exp_rdy;
        apply_reset();
        for (int i = 0; i < 5; i++) set_req(i, 1'b1, 8'(8'h30 + i), 64'(64'h200 + i));
        for (int i = 0; i < 4; i++) push_exp(i, 8'(8'h30 + i), 64'(64'h200 + i), 1'b1, i);
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_rdy = 8'(1 << k);
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++; $display("FAIL exh_grant_%0d got=%h exp=%h", k, req_ready, exp_rdy);
            end
            step();
        end
        #1;
        checks++;
        if (req_ready !== '0 || outstanding !== 3'd4 || busy !== 8'h0F) begin
            errors++; $display("FAIL exh_stall got=%h/%0d/%h exp=00/4/0f", req_ready, outstanding, busy);
        end
        step();
        set_req(5, 1'b0, 8'h55, 64'h5555);
        push_exp(5, 8'h55, 64'h5555, 1'b0, 0);
        #1;
        checks++;
        if (req_ready !== 8'h20) begin
            errors++; $display("FAIL exh_nb_grant got=%h exp=20", req_ready);
        end
        step();
        req_valid[5] = 1'b0;
        #1;
        checks++;
        if (req_ready !== '0 || outstanding !== 3'd4 || busy !== 8'h0F) begin
            errors++; $display("FAIL exh_after_nb got=%h/%0d/%h exp=00/4/0f", req_ready, outstanding, busy);
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_backpressure();
        apply_reset();
        out_ready = 1'b0;
        set_req(2, 1'b1, 8'h42, 64'hCAFE);
        push_exp(2, 8'h42, 64'hCAFE, 1'b1, 0);
        #1;
        checks++;
        if (req_ready !== 8'h04) begin
            errors++; $display("FAIL bp_ready got=%h exp=04", req_ready);
        end
        step();
        req_valid[2] = 1'b0;
        set_req(3, 1'b0, 8'h43, 64'hBEEF);
        push_exp(3, 8'h43, 64'hBEEF, 1'b0, 0);
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                rsp_valid = 1'b1; rsp_tag = 2'd0; rsp_data = 64'h77;
            end
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_method !== 8'h42 || out_params !== 64'hCAFE ||
                out_src !== 3'd2 || out_tag !== 2'd0 || req_ready !== '0) begin
                errors++;
                $display("FAIL bp_hold_%0d got=%b/%h/%h/%0d/%0d/%h exp=1/42/cafe/2/0/00",
                         k, out_valid, out_method, out_params, out_src, out_tag, req_ready);
            end
            step();
            if (k == 1) begin
                rsp_valid = 1'b0;
                checks++;
                if (err_unexp_tag !== 1'b1 || cpl_valid !== '0 || outstanding !== 3'd1) begin
                    errors++;
                    $display("FAIL bp_unexp got=%b/%h/%0d exp=1/00/1", err_unexp_tag, cpl_valid, outstanding);
                end
            end
        end
        checks++;
        if (err_unexp_tag !== 1'b0) begin
            errors++; $display("FAIL bp_err_pulse got=%b exp=0", err_unexp_tag);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 8'h08) begin
            errors++; $display("FAIL bp_release_ready got=%h exp=08", req_ready);
        end
        step();
        req_valid = '0;
        step();
        rsp_valid = 1'b1; rsp_tag = 2'd0; rsp_data = 64'h99;
        step();
        rsp_valid = 1'b0;
        checks++;
        if (cpl_valid !== 8'h04 || cpl_data !== 64'h99 || err_unexp_tag !== 1'b0 || busy !== '0) begin
            errors++;
            $display("FAIL bp_cpl got=%h/%h/%b/%h exp=04/99/0/00", cpl_valid, cpl_data, err_unexp_tag, busy);
        end
    endtask

    task automatic test_enable();
        apply_reset();
        enable = 1'b0;
        set_req(6, 1'b0, 8'h66, 64'h666);
        #1;
        checks++;
        if (req_ready !== '0) begin
            errors++; $display("FAIL en_off_ready got=%h exp=00", req_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL en_off_valid got=%b exp=0", out_valid);
        end
        enable = 1'b1;
        push_exp(6, 8'h66, 64'h666, 1'b0, 0);
        #1;
        checks++;
        if (req_ready !== 8'h40) begin
            errors++; $display("FAIL en_on_ready got=%h exp=40", req_ready);
        end
        step();
        req_valid = '0;
        out_ready = 1'b0;
        enable = 1'b0;
        step();
        step();
        checks++;
        if (out_valid !== 1'b1 || out_src !== 3'd6) begin
            errors++; $display("FAIL en_held got=%b/%0d exp=1/6", out_valid, out_src);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL en_drain got=%b exp=0", out_valid);
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        set_req(0, 1'b1, 8'h60, 64'h600);
        set_req(1, 1'b1, 8'h61, 64'h601);
        push_exp(0, 8'h60, 64'h600, 1'b1, 0);
        push_exp(1, 8'h61, 64'h601, 1'b1, 1);
        step();
        step();
        req_valid = '0;
        step();
        checks++;
        if (outstanding !== 3'd2 || busy !== 8'h03) begin
            errors++; $display("FAIL mid_pending got=%0d/%h exp=2/03", outstanding, busy);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (outstanding !== 3'd0 || busy !== '0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset got=%0d/%h/%b exp=0/00/0", outstanding, busy, out_valid);
        end
        rsp_valid = 1'b1; rsp_tag = 2'd1; rsp_data = 64'h33;
        step();
        rsp_valid = 1'b0;
        checks++;
        if (err_unexp_tag !== 1'b1 || cpl_valid !== '0) begin
            errors++; $display("FAIL mid_stale_rsp got=%b/%h exp=1/00", err_unexp_tag, cpl_valid);
        end
    endtask

    task automatic test_drain();
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got=%0d exp=0 pending invokes", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_nonblocking();
        test_blocking();
        test_drain();
        test_round_robin();
        test_drain();
        test_tag_exhaust();
        test_drain();
        test_backpressure();
        test_drain();
        test_enable();
        test_drain();
        test_reset_midflight();
        test_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
